// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // RV32 load/store width and sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte enables touched by an access of the given width at addr[1:0].
  // Alignment is validated elsewhere; this only steers lanes.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: lane_mask = 4'b0001 << addr_lo;
      F3_H, F3_HU: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        lane_mask = 4'b1111;
      default:     lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Four byte-wide banks forming a little-endian word memory with per-lane
// write enables and an asynchronous full-word read.
module dmem_byte_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 CLK,
  input  logic [ADDR_BITS-3:0] i_word_addr,
  input  logic [3:0]           i_we,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  localparam int DEPTH = 1 << (ADDR_BITS - 2);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] r_bank [0:DEPTH-1];

    // Lane write: only the enabled byte of the addressed word changes.
    // NOTE: storage arrays carry no reset; clearing them would turn the banks
    // into flops and the contents are undefined until written anyway.
    always_ff @(posedge CLK) begin
      if (i_we[g]) r_bank[i_word_addr] <= i_wdata[8*g +: 8];
    end

    assign o_rdata[8*g +: 8] = r_bank[i_word_addr];
  end

endmodule

// File: rtl/dmem_controller.sv
// Multi-cycle data-memory controller: latches a MEM-stage request, stalls the
// pipeline for a fixed latency, then commits a store or returns an extended load.
module dmem_controller #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        ERROR
);
  import dmem_pkg::*;

  state_t                r_state;
  logic [3:0]            r_count;
  logic                  r_is_store;
  logic [2:0]            r_funct3;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [31:0]           r_wdata;

  logic                  w_req;
  logic                  w_legal;
  logic                  w_last;
  logic [3:0]            w_we;
  logic [31:0]           w_store_word;
  logic [31:0]           w_rword;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load_ext;
  logic                  w_unused;

  // High address bits alias onto the array.
  assign w_unused = ^ADDRESS[31:ADDR_BITS];

  assign w_req  = READ | WRITE;
  assign w_last = (r_state == WAIT) && (r_count == 4'd0);

  // Legality of the incoming request: FUNCT3 valid for the op and aligned.
  // NOTE: every branch assigns w_legal via the default first, so no latch forms.
  always_comb begin
    w_legal = 1'b0;
    case (FUNCT3)
      F3_B:    w_legal = 1'b1;
      F3_BU:   w_legal = !WRITE;
      F3_H:    w_legal = !ADDRESS[0];
      F3_HU:   w_legal = !WRITE && !ADDRESS[0];
      F3_W:    w_legal = (ADDRESS[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Replicate the store byte/half across all lanes; the mask picks the lane.
  always_comb begin
    w_store_word = r_wdata;
    case (r_funct3)
      F3_B:    w_store_word = {4{r_wdata[7:0]}};
      F3_H:    w_store_word = {2{r_wdata[15:0]}};
      default: w_store_word = r_wdata;
    endcase
  end

  // A reset on the commit edge must suppress the write.
  assign w_we = (w_last && r_is_store && !RESET) ? lane_mask(r_funct3, r_addr[1:0])
                                                 : 4'b0000;

  dmem_byte_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .CLK         (CLK),
    .i_word_addr (r_addr[ADDR_BITS-1:2]),
    .i_we        (w_we),
    .i_wdata     (w_store_word),
    .o_rdata     (w_rword)
  );

  // Move the addressed byte/half to bit 0, then extend by FUNCT3.
  assign w_shifted = w_rword >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_ext = w_rword;
    case (r_funct3)
      F3_B:    w_load_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
      F3_BU:   w_load_ext = {24'h0,               w_shifted[7:0]};
      F3_H:    w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   w_load_ext = {16'h0,               w_shifted[15:0]};
      default: w_load_ext = w_rword;
    endcase
  end

  // Request capture in IDLE; only consumed in WAIT, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (r_state == IDLE && w_req) begin
      r_is_store <= WRITE;
      r_funct3   <= FUNCT3;
      r_addr     <= ADDRESS[ADDR_BITS-1:0];
      r_wdata    <= WRITE_DATA;
    end
  end

  // Control FSM, latency counter, result and error registers.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_count   <= 4'd0;
      READ_DATA <= 32'h0;
      ERROR     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_legal) begin
              r_state <= WAIT;
              r_count <= 4'(LATENCY - 1);
            end else begin
              r_state   <= DONE;
              ERROR     <= 1'b1;
              READ_DATA <= 32'h0;
            end
          end
        end
        WAIT: begin
          if (r_count == 4'd0) begin
            r_state <= DONE;
            ERROR   <= 1'b0;
            if (!r_is_store) READ_DATA <= w_load_ext;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          ERROR   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall: new request seen in IDLE, or any WAIT cycle.
  assign BUSYWAIT = !RESET && ((r_state == IDLE && w_req) || r_state == WAIT);

endmodule

// File: tb/tb_dmem_controller.sv
// Self-checking bench for dmem_controller: directed table, reset corner case,
// and randomized traffic against a byte-level reference model.
module tb_dmem_controller;
  import dmem_pkg::*;

  localparam int ADDR_BITS = 10;
  localparam int LATENCY   = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        ERROR;

  dmem_controller #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .READ       (READ),
    .WRITE      (WRITE),
    .FUNCT3     (FUNCT3),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSYWAIT   (BUSYWAIT),
    .ERROR      (ERROR)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state: byte memory and the value READ_DATA should hold.
  logic [7:0]  mem_m [0:1023];
  logic [31:0] m_rdata;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One request: apply in IDLE, count stall cycles, sample results in DONE,
  // then idle one cycle and sample again.
  task automatic access(input logic wr, input logic rd, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit scramble,
                        output int busy, output logic [31:0] rdata, output logic err,
                        output logic err_next, output logic busy_next);
    @(negedge CLK);
    WRITE = wr; READ = rd; FUNCT3 = f3; ADDRESS = addr; WRITE_DATA = wdata;
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!BUSYWAIT) break;
      busy++;
      @(negedge CLK);
      if (scramble) begin
        READ       = 1'($urandom);
        WRITE      = 1'($urandom);
        FUNCT3     = 3'($urandom);
        ADDRESS    = $urandom;
        WRITE_DATA = $urandom;
      end
    end
    rdata = READ_DATA;
    err   = ERROR;
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
    #1;
    err_next  = ERROR;
    busy_next = BUSYWAIT;
  endtask

  task automatic run_check(input string name, input logic wr, input logic rd,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit scramble,
                           input logic [31:0] exp_rdata, input logic exp_err);
    int          busy;
    logic [31:0] rdata;
    logic        err, err_next, busy_next;
    access(wr, rd, f3, addr, wdata, scramble, busy, rdata, err, err_next, busy_next);
    check({name, "_busy"},     32'(busy), exp_err ? 32'd1 : 32'(LATENCY + 1));
    check({name, "_rdata"},    rdata, exp_rdata);
    check({name, "_err"},      32'(err), 32'(exp_err));
    check({name, "_err_next"}, 32'(err_next), 32'd0);
    check({name, "_idle"},     32'(busy_next), 32'd0);
  endtask

  // Behavioural model of one access, straight from the load/store rules.
  task automatic model_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output logic [31:0] exp_rdata, output logic exp_err);
    int          a;
    int          nbytes;
    bit          legal;
    logic [31:0] v;
    a      = int'(addr[9:0]);
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal  = wr ? (f3 inside {3'b000, 3'b001, 3'b010})
                : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    legal  = legal && (a % nbytes == 0);
    exp_err = !legal;
    if (!legal) begin
      m_rdata = 32'h0;
    end else if (wr) begin
      for (int i = 0; i < nbytes; i++) mem_m[a + i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
      if (!f3[2] && nbytes == 1) v = 32'($signed(v[7:0]));
      if (!f3[2] && nbytes == 2) v = 32'($signed(v[15:0]));
      m_rdata = v;
    end
    exp_rdata = m_rdata;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        wr, rd;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;

    // ---------------- reset ----------------
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; FUNCT3 = F3_W; ADDRESS = 32'h0; WRITE_DATA = 32'h0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_busy_held", 32'(BUSYWAIT), 32'd0);
    check("rst_rdata", READ_DATA, 32'h0);
    check("rst_err", 32'(ERROR), 32'd0);
    @(negedge CLK);
    RESET = 1'b0; READ = 1'b0;
    #1;
    check("post_rst_busy", 32'(BUSYWAIT), 32'd0);

    // ---------------- directed table ----------------
    tbl.push_back('{1'b1, 1'b0, F3_W,   32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, "sw_10"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'h010, 32'h0,        32'hDEADBEEF, 1'b0, "lw_10"});
    tbl.push_back('{1'b0, 1'b1, F3_B,   32'h013, 32'h0,        32'hFFFFFFDE, 1'b0, "lb_13"});
    tbl.push_back('{1'b0, 1'b1, F3_BU,  32'h013, 32'h0,        32'h000000DE, 1'b0, "lbu_13"});
    tbl.push_back('{1'b0, 1'b1, F3_H,   32'h010, 32'h0,        32'hFFFFBEEF, 1'b0, "lh_10"});
    tbl.push_back('{1'b0, 1'b1, F3_HU,  32'h012, 32'h0,        32'h0000DEAD, 1'b0, "lhu_12"});
    tbl.push_back('{1'b1, 1'b0, F3_B,   32'h011, 32'hFFFFFF55, 32'h0000DEAD, 1'b0, "sb_11"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'h010, 32'h0,        32'hDEAD55EF, 1'b0, "lw_10_after_sb"});
    tbl.push_back('{1'b1, 1'b0, F3_W,   32'h000, 32'h0BADF00D, 32'hDEAD55EF, 1'b0, "sw_00"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'h012, 32'h0,        32'h00000000, 1'b1, "lw_misaligned"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'h000, 32'h0,        32'h0BADF00D, 1'b0, "lw_00"});
    tbl.push_back('{1'b1, 1'b0, F3_H,   32'h001, 32'h0000FFFF, 32'h00000000, 1'b1, "sh_misaligned"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'h000, 32'h0,        32'h0BADF00D, 1'b0, "lw_00_unchanged"});
    tbl.push_back('{1'b1, 1'b1, F3_W,   32'h030, 32'hA5A5A5A5, 32'h0BADF00D, 1'b0, "rdwr_30"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'h030, 32'h0,        32'hA5A5A5A5, 1'b0, "lw_30"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'hFFFF_F410, 32'h0,  32'hDEAD55EF, 1'b0, "lw_alias_10"});
    tbl.push_back('{1'b1, 1'b0, F3_BU,  32'h000, 32'h000000FF, 32'h00000000, 1'b1, "store_bad_f3"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'h000, 32'h0,        32'h0BADF00D, 1'b0, "lw_00_after_bad"});
    tbl.push_back('{1'b1, 1'b0, F3_W,   32'h020, 32'h11223344, 32'h0BADF00D, 1'b0, "sw_20"});
    tbl.push_back('{1'b0, 1'b1, 3'b011, 32'h020, 32'h0,        32'h00000000, 1'b1, "load_bad_f3"});
    tbl.push_back('{1'b0, 1'b1, F3_W,   32'h020, 32'h0,        32'h11223344, 1'b0, "lw_20"});

    for (int i = 0; i < tbl.size(); i++)
      run_check(tbl[i].name, tbl[i].wr, tbl[i].rd, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                1'b0, tbl[i].exp_rdata, tbl[i].exp_err);

    // ---------------- reset on the store's commit edge ----------------
    @(negedge CLK);
    WRITE = 1'b1; READ = 1'b0; FUNCT3 = F3_W; ADDRESS = 32'h020; WRITE_DATA = 32'h12345678;
    #1;
    check("rstmid_busy_c0", 32'(BUSYWAIT), 32'd1);
    for (int c = 1; c < LATENCY; c++) @(negedge CLK);
    #1;
    check("rstmid_busy_wait", 32'(BUSYWAIT), 32'd1);
    @(negedge CLK);
    RESET = 1'b1; WRITE = 1'b0;
    #1;
    check("rstmid_busy_forced", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rstmid_busy_after", 32'(BUSYWAIT), 32'd0);
    check("rstmid_rdata", READ_DATA, 32'h0);
    check("rstmid_err", 32'(ERROR), 32'd0);
    @(negedge CLK);
    #1;
    check("rstmid_still_idle", 32'(BUSYWAIT), 32'd0);
    run_check("lw_20_old", 1'b0, 1'b1, F3_W, 32'h020, 32'h0, 1'b0, 32'h11223344, 1'b0);

    // ---------------- randomized traffic vs model ----------------
    m_rdata = 32'h11223344;
    for (int w = 0; w < 16; w++) begin
      wdata = $urandom;
      addr  = 32'h100 + 32'(4 * w);
      model_op(1'b1, F3_W, addr, wdata, exp_rd, exp_err);
      run_check($sformatf("fill_%0d", w), 1'b1, 1'b0, F3_W, addr, wdata, 1'b0, exp_rd, exp_err);
    end

    for (int n = 0; n < 80; n++) begin
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end else begin
        f3 = 3'($urandom);
      end
      addr = {22'($urandom), 10'h100 | 10'($urandom_range(0, 63))};
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        else if (f3[1:0] != 2'd0) addr[1:0] = 2'b00;
      end
      wdata = $urandom;
      model_op(wr, f3, addr, wdata, exp_rd, exp_err);
      run_check($sformatf("rnd_%0d", n), wr, rd, f3, addr, wdata, 1'b1, exp_rd, exp_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Multi-cycle RV32IM data-memory controller for the MEM stage. Serves loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) from the MEM-stage control signals against an internal byte-addressed memory with a fixed access latency. It drives BUSYWAIT, the stall input every pipeline register samples, and supplies READ_DATA, which feeds the MEM/WB register's DMEM_OUT input.

## Interface
Parameters:
- ADDR_BITS, 10: byte-address width of the internal array (2^ADDR_BITS bytes).
- LATENCY, 4: wait cycles per access; legal range 1..15.

Ports:
- CLK  in  1  clock; all state changes on the posedge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  load request from the MEM stage.
- WRITE  in  1  store request from the MEM stage; takes priority if READ is also high.
- FUNCT3  in  3  RV32 load/store width and sign code.
- ADDRESS  in  32  byte address (ALU result); only bits [ADDR_BITS-1:0] are used.
- WRITE_DATA  in  32  store data (rs2); the low byte/half is used for SB/SH.
- READ_DATA  out  32  extended load result; registered.
- BUSYWAIT  out  1  stall to all pipeline registers; combinational.
- ERROR  out  1  misaligned access or illegal FUNCT3; valid while in DONE.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On READ|WRITE, latch op, FUNCT3, ADDRESS and WRITE_DATA.
  - Legal request: load counter with LATENCY-1 and go to WAIT.
  - Illegal request: go straight to DONE with ERROR=1.
- WAIT: if counter==0 go to DONE, else decrement.
  - On the WAIT->DONE edge, a store commits its byte lanes to the array, or a load registers its extended result into READ_DATA.
- DONE: go to IDLE unconditionally. The pipeline advances on this edge, so the request in the next IDLE cycle is a new one.
- Illegal requests:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Store FUNCT3 not in {000,001,010}.
  - Load FUNCT3 not in {000,001,010,100,101}.
  - An illegal request performs no array write, and READ_DATA is set to 0.
- Data format:
  - Little-endian.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH write only the addressed lanes; other bytes are unchanged.
- Address bits above ADDR_BITS are ignored (aliasing).
- BUSYWAIT = !RESET & ((IDLE & (READ|WRITE)) | WAIT).
- ERROR is a register: set on entry to DONE, cleared on leaving DONE.
- Reset values: state=IDLE, counter=0, READ_DATA=0, ERROR=0, BUSYWAIT=0. The array is not cleared.
- Reset mid-operation: return to IDLE. A store not yet committed is discarded, and READ_DATA is cleared.

## Timing
- Request first visible in cycle 0 (IDLE):
  - BUSYWAIT is high in cycles 0..LATENCY (the WAIT state occupies cycles 1..LATENCY).
  - DONE is cycle LATENCY+1: BUSYWAIT low, and READ_DATA valid before that cycle's posedge.
  - Total stall: LATENCY+1 cycles.
- Illegal request: BUSYWAIT high in cycle 0 only; DONE in cycle 1 with ERROR=1.
- Back-to-back requests: minimum LATENCY+2 cycles apart.
- READ/WRITE changing while in WAIT or DONE is ignored; the latched copy is used.
- READ_DATA holds its value until the next load completes, an illegal request completes, or reset.

## Structure
- Package dmem_pkg holds:
  - State enum: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - FUNCT3 constants: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - Lane-mask function (FUNCT3, addr[1:0]) -> 4-bit byte enable.
- Sub-module dmem_byte_array:
  - Four byte-wide banks with word address [ADDR_BITS-1:2].
  - Per-lane write enable.
  - Combinational read of the full word.
- dmem_controller contains the FSM, counter, alignment check, lane steering and extension.

## Test plan
- LATENCY=4: SW 0xDEADBEEF to 0x10, then LW from 0x10:
  - READ_DATA=0xDEADBEEF.
  - BUSYWAIT high exactly 5 cycles per access, then low 1 cycle.
- After that store: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF (other lanes untouched).
- LW at 0x12 and SH at 0x01:
  - BUSYWAIT high 1 cycle, then ERROR=1 for one cycle.
  - READ_DATA=0.
  - Subsequent LW 0x00 shows unchanged memory.
- RESET asserted during WAIT of SW 0x12345678 to 0x20:
  - Next cycle: state IDLE, BUSYWAIT=0, READ_DATA=0.
  - Later LW 0x20 returns the old contents.
- READ=WRITE=1 at 0x30 with data 0xA5A5A5A5: treated as a store; LW 0x30 -> 0xA5A5A5A5.
